// File: rtl/branch_resolver.sv
// Branch/jump resolver: registered PC select with RUN/SQUASH/HALT control.
// Optional statistics counters (br_count, taken_count) under `BRANCH_STATS_EN`.
module branch_resolver #(
  parameter int WIDTH = 32,
  parameter int OPW   = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   opcode,
  input  logic             exception_flag,
  output logic [1:0]       PC_src,
  output logic             squash,
  output logic             halted,
  output logic [1:0]       o_dbg_state
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
`endif
);

  // Handshake: an instruction is consumed when in_valid && !stall; stall freezes everything.
  localparam logic [OPW-1:0] OP_J   = OPW'(2);
  localparam logic [OPW-1:0] OP_JAL = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(4);
  localparam logic [OPW-1:0] OP_BNE = OPW'(5);
  localparam logic [OPW-1:0] OP_BLT = OPW'(6);
  localparam logic [OPW-1:0] OP_BGE = OPW'(7);
  localparam logic [OPW-1:0] OP_JR  = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(63);

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_EXC  = 2'b01;
  localparam logic [1:0] PC_TGT  = 2'b10;
  localparam logic [1:0] PC_HALT = 2'b11;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SQUASH = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  state_t     r_state, w_next_state;
  logic [1:0] r_pc_src, w_next_pc;
  logic       r_squash, w_next_squash;
  logic       w_accept, w_is_br, w_taken;
  logic       w_cnt_br, w_cnt_taken;

  assign w_accept = in_valid && !stall;

  always_comb begin
    w_is_br = 1'b1;
    w_taken = 1'b0;
    case (opcode)
      OP_BEQ:              w_taken = (A == B);
      OP_BNE:              w_taken = (A != B);
      OP_BLT:              w_taken = ($signed(A) <  $signed(B));
      OP_BGE:              w_taken = ($signed(A) >= $signed(B));
      OP_J, OP_JAL, OP_JR: w_taken = 1'b1;
      default:             w_is_br = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_pc     = r_pc_src;
    w_next_squash = r_squash;
    w_cnt_br      = 1'b0;
    w_cnt_taken   = 1'b0;
    if (!stall) begin
      w_next_pc     = PC_SEQ;
      w_next_squash = 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (exception_flag) begin
              w_next_pc = PC_EXC;
            end else if (opcode == OP_HLT) begin
              w_next_pc    = PC_HALT;
              w_next_state = S_HALT;
            end else begin
              w_cnt_br    = w_is_br;
              w_cnt_taken = w_taken;
              if (w_taken) begin
                w_next_pc    = PC_TGT;
                w_next_state = S_SQUASH;
              end
            end
          end
        end
        S_SQUASH: begin
          // The wrong-path slot is dropped, but an exception on it still redirects.
          if (w_accept) begin
            w_next_state = S_RUN;
            if (exception_flag) w_next_pc = PC_EXC;
            else                w_next_squash = 1'b1;
          end
        end
        S_HALT:  w_next_pc = PC_HALT;
        default: w_next_state = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_RUN;
      r_pc_src <= PC_SEQ;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pc_src <= w_next_pc;
      r_squash <= w_next_squash;
    end
  end

  assign PC_src      = r_pc_src;
  assign squash      = r_squash;
  assign halted      = (r_state == S_HALT);
  assign o_dbg_state = r_state;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_br_count, r_taken_count;

  // Counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      if (w_cnt_br && (r_br_count != '1))
        r_br_count <= r_br_count + CNT_W'(1);
      if (w_cnt_taken && (r_taken_count != '1))
        r_taken_count <= r_taken_count + CNT_W'(1);
    end
  end

  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;
`else
  logic w_unused;
  assign w_unused = w_cnt_br ^ w_cnt_taken;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expected {halted, squash, PC_src} queued per step.
module tb_branch_resolver;

`ifdef BRANCH_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  localparam logic [6:0] OP_NOP = 7'd0;
  localparam logic [6:0] OP_J   = 7'd2;
  localparam logic [6:0] OP_JAL = 7'd3;
  localparam logic [6:0] OP_BEQ = 7'd4;
  localparam logic [6:0] OP_BNE = 7'd5;
  localparam logic [6:0] OP_BLT = 7'd6;
  localparam logic [6:0] OP_BGE = 7'd7;
  localparam logic [6:0] OP_JR  = 7'd8;
  localparam logic [6:0] OP_HLT = 7'd63;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, exception_flag;
  logic [31:0] A, B;
  logic [6:0]  opcode;
  logic [1:0]  PC_src, o_dbg_state;
  logic        squash, halted;
`ifdef BRANCH_STATS_EN
  logic [TB_CNT_W-1:0] br_count, taken_count;
`endif

  logic [3:0] exp_q[$];
  string      tag_q[$];
  int         n_total = 0;
  int         n_pass  = 0;

  // clock / reset
  always #5 clk = ~clk;

  branch_resolver #(.WIDTH(32), .OPW(7), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .A(A), .B(B), .opcode(opcode), .exception_flag(exception_flag),
    .PC_src(PC_src), .squash(squash), .halted(halted), .o_dbg_state(o_dbg_state)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // scoreboard: pop one expected {halted, squash, PC_src}
  task automatic check_out();
    logic [3:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, {28'd0, halted, squash, PC_src}, {28'd0, e});
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] s);
    check_val(tag, {30'd0, o_dbg_state}, {30'd0, s});
  endtask

  // driver: inputs applied 1ns after a rising edge, result sampled 1ns after the next
  task automatic step(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [6:0] op, input logic e, input logic [3:0] expv, input string tag);
    in_valid = v; stall = s; A = a; B = b; opcode = op; exception_flag = e;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic do_reset(input logic s, input string tag);
    rst = 1'b0; stall = s;
    exp_q.push_back(4'b0000);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    check_out();
    check_state({tag, "_state"}, 2'd0);
    rst = 1'b1; stall = 1'b0;
  endtask

  initial begin
    logic [6:0] ops[8];
    ops = '{OP_NOP, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JR};
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; A = '0; B = '0;
    opcode = OP_NOP; exception_flag = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0, "reset");

    step(1, 0, 5, 5, OP_BEQ, 0, 4'b0010, "beq_taken");
    check_state("after_taken_state", 2'd1);
    step(1, 0, 5, 5, OP_BEQ, 0, 4'b0100, "beq_squashed");
    check_state("after_squash_state", 2'd0);
    step(1, 0, 5, 6, OP_BEQ, 0, 4'b0000, "beq_not_taken");
    step(1, 0, 5, 6, OP_BNE, 0, 4'b0010, "bne_taken");
    step(0, 0, 0, 0, OP_NOP, 0, 4'b0000, "squash_idle");
    check_state("squash_idle_state", 2'd1);
    step(1, 0, 0, 0, OP_NOP, 0, 4'b0100, "squash_after_idle");
    step(1, 0, 32'hFFFF_FFFF, 1, OP_BLT, 0, 4'b0010, "blt_signed_taken");
    step(1, 0, 0, 0, OP_NOP, 0, 4'b0100, "blt_slot");
    step(1, 0, 32'hFFFF_FFFF, 1, OP_BGE, 0, 4'b0000, "bge_signed_not_taken");
    step(1, 0, 1, 32'hFFFF_FFFF, OP_BGE, 0, 4'b0010, "bge_signed_taken");
    step(1, 0, 0, 0, OP_NOP, 0, 4'b0100, "bge_slot");
    step(1, 0, 32'h8000_0000, 32'h7FFF_FFFF, OP_BLT, 0, 4'b0010, "blt_min_vs_max");
    step(1, 0, 0, 0, OP_NOP, 0, 4'b0100, "blt_min_slot");
    step(1, 0, 0, 0, OP_JR, 0, 4'b0010, "jr_taken");
    step(1, 0, 0, 0, OP_NOP, 1, 4'b0001, "exc_in_squash_slot");
    check_state("exc_slot_state", 2'd0);
    step(1, 0, 0, 0, OP_J, 0, 4'b0010, "j_first");
    step(1, 0, 0, 0, OP_J, 0, 4'b0100, "j_back_to_back_dropped");
    step(1, 0, 1, 2, OP_BEQ, 0, 4'b0000, "after_b2b");
    step(1, 0, 7, 7, OP_BEQ, 1, 4'b0001, "exc_beats_taken");
    check_state("exc_beats_taken_state", 2'd0);
    step(1, 0, 0, 0, OP_HLT, 1, 4'b0001, "exc_beats_hlt");
    check_state("exc_beats_hlt_state", 2'd0);
    step(0, 0, 0, 0, OP_NOP, 0, 4'b0000, "idle_run");
    step(1, 1, 9, 9, OP_BEQ, 0, 4'b0000, "stall_in_run");

    for (int i = 0; i < 4; i++)
      step(1, 0, $urandom, $urandom, 7'(16 + $urandom_range(0, 15)), 0, 4'b0000, "non_branch");

    step(1, 0, 0, 0, OP_JAL, 0, 4'b0010, "jal_taken");
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 0, OP_NOP, 1, 4'b0010, "jal_stall_hold");
    check_state("stall_state", 2'd1);
    step(1, 0, 0, 0, OP_NOP, 0, 4'b0100, "jal_release_squash");

    do_reset(1'b0, "reset_pre_squash");
    step(1, 0, 0, 0, OP_J, 0, 4'b0010, "j_before_reset");
    do_reset(1'b0, "reset_mid_squash");
    step(1, 0, 0, 0, OP_NOP, 0, 4'b0000, "no_squash_after_reset");

    step(1, 0, 0, 0, OP_HLT, 0, 4'b1011, "hlt");
    check_state("hlt_state", 2'd2);
    for (int i = 0; i < 10; i++)
      step(1, 0, $urandom, $urandom, ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
           4'b1011, "halt_sticky");
    step(0, 1, 0, 0, OP_NOP, 0, 4'b1011, "halt_stall");
    do_reset(1'b1, "reset_in_halt_with_stall");
    step(1, 0, 1, 2, OP_BNE, 0, 4'b0010, "bne_after_halt_reset");

`ifdef BRANCH_STATS_EN
    do_reset(1'b0, "reset_stats");
    check_val("br_count_reset", 32'(br_count), 32'd0);
    check_val("taken_count_reset", 32'(taken_count), 32'd0);
    step(1, 0, 1, 2, OP_BEQ, 0, 4'b0000, "stats_not_taken");
    check_val("br_count_nt", 32'(br_count), 32'd1);
    check_val("taken_count_nt", 32'(taken_count), 32'd0);
    do_reset(1'b0, "reset_stats2");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, OP_J, 0, 4'b0010, "stats_j");
      check_val("br_count_sat", 32'(br_count), (i < 3) ? 32'(i + 1) : 32'd3);
      check_val("taken_count_sat", 32'(taken_count), (i < 3) ? 32'(i + 1) : 32'd3);
      step(1, 0, 0, 0, OP_NOP, 0, 4'b0100, "stats_slot");
    end
`endif

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
